pattern_pixel_engine: RTL and testbench

- Parametrised test-pattern pixel producer for the VGA pixel bus. It replaces the fixed counter-to-colour mapping with four selectable patterns, configurable colour depth, and animation driven by a frame counter.
- Registered RGB output with blanking suppression.
- Sits between the VGA timing generator (source of H_CNT, next_V_CNT, NEXT_FRAME, H_BLANKING) and the DAC output stage.
- Used for board bring-up and monitor-timing checks before the Pong renderer is attached.

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/bar_counter.sv | 42 ++++
 rtl/pattern_pixel_engine.sv | 113 +++++++++++
 tb/tb_pattern_pixel_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and constants for the test-pattern pixel path.
package pixel_pkg;

    localparam int COLOR_WID = 4;

    typedef enum logic [1:0] {
        PM_GRADIENT = 2'd0,
        PM_BARS     = 2'd1,
        PM_CHECKER  = 2'd2,
        PM_SOLID    = 2'd3
    } pattern_mode_t;

    typedef struct packed {
        logic [COLOR_WID-1:0] r;
        logic [COLOR_WID-1:0] g;
        logic [COLOR_WID-1:0] b;
    } rgb_t;

    localparam logic [COLOR_WID-1:0] COLOR_MAX  = {COLOR_WID{1'b1}};
    localparam logic [COLOR_WID-1:0] COLOR_ZERO = {COLOR_WID{1'b0}};

    // Channel enables {r,g,b} for the solid-colour phase: red, green, blue, white.
    function automatic logic [2:0] phase_mask(input logic [1:0] phase);
        logic [2:0] mask;
        case (phase)
            2'd0:    mask = 3'b100;
            2'd1:    mask = 3'b010;
            2'd2:    mask = 3'b001;
            2'd3:    mask = 3'b111;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bar_counter.sv
// Tracks pixel position within a colour bar and which bar is current.
module bar_counter #(
    parameter int BAR_W     = 80,
    parameter int BAR_COUNT = 8,
    parameter int PX_W      = (BAR_W > 1) ? $clog2(BAR_W) : 1,
    parameter int IDX_W     = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active_i,
    input  logic             clear_i,
    output logic [IDX_W-1:0] bar_idx_o
);

    logic [PX_W-1:0]  bar_px_q;
    logic [IDX_W-1:0] bar_idx_q;

    // Advance within the bar on active pixels; the index saturates on the last bar.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            bar_px_q  <= {PX_W{1'b0}};
            bar_idx_q <= {IDX_W{1'b0}};
        end else if (active_i) begin
            if (bar_px_q == PX_W'(BAR_W - 1)) begin
                bar_px_q <= {PX_W{1'b0}};
                if (bar_idx_q != IDX_W'(BAR_COUNT - 1)) begin
                    bar_idx_q <= bar_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end else begin
                    bar_idx_q <= bar_idx_q;
                end
            end else begin
                bar_px_q <= bar_px_q + {{(PX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            bar_px_q  <= bar_px_q;
            bar_idx_q <= bar_idx_q;
        end
    end

    assign bar_idx_o = bar_idx_q;

endmodule

// File: rtl/pattern_pixel_engine.sv
// Test-pattern pixel producer: mode latch, animation frame counter,
// pattern selection and registered, blank-suppressed RGB output.
module pattern_pixel_engine
    import pixel_pkg::*;
#(
    parameter int H_CNT_WID = 10,
    parameter int V_CNT_WID = 10,
    parameter int COLOR_WID = 4,
    parameter int H_ACTIVE  = 640,
    parameter int BAR_COUNT = 8,
    parameter int CHK_SHIFT = 5,
    parameter int FRAME_WID = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode_i,
    input  logic                 freeze_i,
    input  logic                 pixIf_NEXT_FRAME,
    input  logic                 pixIf_H_BLANKING,
    input  logic [H_CNT_WID-1:0] pixIf_H_CNT,
    input  logic [V_CNT_WID-1:0] pixIf_next_V_CNT,
    output logic [COLOR_WID-1:0] pixIf_r,
    output logic [COLOR_WID-1:0] pixIf_g,
    output logic [COLOR_WID-1:0] pixIf_b,
    output logic [FRAME_WID-1:0] frame_cnt_o
);

    localparam int BAR_W = H_ACTIVE / BAR_COUNT;
    localparam int IDX_W = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
    localparam int PIX_W = 3 * COLOR_WID;

    pattern_mode_t        mode_q, mode_d;
    logic [FRAME_WID-1:0] frame_q, frame_d;
    logic [PIX_W-1:0]     rgb_q, rgb_d;
    logic [PIX_W-1:0]     pix_s;
    logic [IDX_W-1:0]     bar_idx_s;
    logic [2:0]           bar_k_s;
    logic [H_CNT_WID-1:0] chk_sum_s;
    logic                 chk_cell_s;
    logic [2:0]           solid_mask_s;

    bar_counter #(
        .BAR_W     (BAR_W),
        .BAR_COUNT (BAR_COUNT),
        .IDX_W     (IDX_W)
    ) u_bar_counter (
        .clk       (clk),
        .rst       (rst),
        .active_i  (!pixIf_H_BLANKING),
        .clear_i   (pixIf_H_BLANKING),
        .bar_idx_o (bar_idx_s)
    );

    assign bar_k_s      = 3'(bar_idx_s);
    assign chk_sum_s    = pixIf_H_CNT + H_CNT_WID'(frame_q);
    assign chk_cell_s   = chk_sum_s[CHK_SHIFT] ^ pixIf_next_V_CNT[CHK_SHIFT];
    assign solid_mask_s = phase_mask(frame_q[FRAME_WID-1 -: 2]);

    // Mode takes effect in the pulse cycle itself; the pixel still sees the old frame count.
    always_comb begin
        mode_d  = mode_q;
        frame_d = frame_q;
        pix_s   = {PIX_W{1'b0}};
        rgb_d   = {PIX_W{1'b0}};

        if (pixIf_NEXT_FRAME) begin
            mode_d = pattern_mode_t'(mode_i);
            if (!freeze_i) begin
                frame_d = frame_q + {{(FRAME_WID-1){1'b0}}, 1'b1};
            end else begin
                frame_d = frame_q;
            end
        end else begin
            mode_d  = mode_q;
            frame_d = frame_q;
        end

        case (mode_d)
            PM_GRADIENT: pix_s = PIX_W'({pixIf_next_V_CNT, pixIf_H_CNT});
            PM_BARS:     pix_s = {{COLOR_WID{bar_k_s[2]}}, {COLOR_WID{bar_k_s[1]}},
                                  {COLOR_WID{bar_k_s[0]}}};
            PM_CHECKER:  pix_s = {PIX_W{chk_cell_s}};
            PM_SOLID:    pix_s = {{COLOR_WID{solid_mask_s[2]}}, {COLOR_WID{solid_mask_s[1]}},
                                  {COLOR_WID{solid_mask_s[0]}}};
            default:     pix_s = {PIX_W{1'b0}};
        endcase

        if (pixIf_H_BLANKING) begin
            rgb_d = {PIX_W{1'b0}};
        end else begin
            rgb_d = pix_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= PM_GRADIENT;
            frame_q <= {FRAME_WID{1'b0}};
            rgb_q   <= {PIX_W{1'b0}};
        end else begin
            mode_q  <= mode_d;
            frame_q <= frame_d;
            rgb_q   <= rgb_d;
        end
    end

    assign pixIf_r     = rgb_q[PIX_W-1 -: COLOR_WID];
    assign pixIf_g     = rgb_q[2*COLOR_WID-1 -: COLOR_WID];
    assign pixIf_b     = rgb_q[COLOR_WID-1:0];
    assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_pattern_pixel_engine.sv
// Scoreboard bench for pattern_pixel_engine: stimulus pushes expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_pattern_pixel_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode_i;
    logic       freeze_i;
    logic       nf;
    logic       blank;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [3:0] r_o, g_o, b_o;
    logic [7:0] fc_o;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         due;
        bit         chk_rgb;
        logic [11:0] rgb;
        bit         chk_fc;
        logic [7:0] fc;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    pattern_pixel_engine dut (
        .clk              (clk),
        .rst              (rst),
        .mode_i           (mode_i),
        .freeze_i         (freeze_i),
        .pixIf_NEXT_FRAME (nf),
        .pixIf_H_BLANKING (blank),
        .pixIf_H_CNT      (h_cnt),
        .pixIf_next_V_CNT (v_cnt),
        .pixIf_r          (r_o),
        .pixIf_g          (g_o),
        .pixIf_b          (b_o),
        .frame_cnt_o      (fc_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose output slot has arrived.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: slot %0d missed (now %0d)", e.name, e.due, cyc);
            end else begin
                if (e.chk_rgb) begin
                    n_chk++;
                    if ({r_o, g_o, b_o} !== e.rgb) begin
                        n_fail++;
                        $display("FAIL %s rgb @%0d: got %h required %h", e.name, cyc,
                                 {r_o, g_o, b_o}, e.rgb);
                    end
                end
                if (e.chk_fc) begin
                    n_chk++;
                    if (fc_o !== e.fc) begin
                        n_fail++;
                        $display("FAIL %s frame_cnt @%0d: got %0d required %0d", e.name, cyc,
                                 fc_o, e.fc);
                    end
                end
            end
        end
    end

    function automatic logic [11:0] bar_rgb(input int k);
        logic [2:0] kk;
        kk = 3'(k);
        return {{4{kk[2]}}, {4{kk[1]}}, {4{kk[0]}}};
    endfunction

    function automatic logic [11:0] phase_rgb(input int f);
        logic [7:0] ff;
        ff = 8'(f);
        case (ff[7:6])
            2'd0:    return 12'hF00;
            2'd1:    return 12'h0F0;
            2'd2:    return 12'h00F;
            default: return 12'hFFF;
        endcase
    endfunction

    // Drive one pixel cycle and queue its expected output for the next cycle.
    task automatic step(input bit r_, input logic [1:0] m, input bit frz, input bit nf_,
                        input bit bl, input int h, input int v,
                        input bit crgb, input logic [11:0] ergb,
                        input bit cfc, input logic [7:0] efc, input string nm);
        exp_t e;
        rst      = r_;
        mode_i   = m;
        freeze_i = frz;
        nf       = nf_;
        blank    = bl;
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        e.due     = cyc + 1;
        e.chk_rgb = crgb;
        e.rgb     = ergb;
        e.chk_fc  = cfc;
        e.fc      = efc;
        e.name    = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] ex;
        rst = 1'b1; mode_i = 2'd0; freeze_i = 1'b0; nf = 1'b0; blank = 1'b0;
        h_cnt = 10'd0; v_cnt = 10'd0;
        @(posedge clk);
        #1;

        // Reset during active pixels with bars requested
        step(1, 2'd1, 0, 0, 0, 100, 7, 1, 12'h000, 1, 8'd0, "reset");
        step(1, 2'd1, 0, 0, 0, 101, 7, 1, 12'h000, 1, 8'd0, "reset2");

        // Gradient: {V=3,H=5} low 12 bits = 0xC05; mode_i=1 ignored mid-frame
        step(0, 2'd1, 0, 0, 0, 5, 3, 1, 12'hC05, 1, 8'd0, "grad_h5v3");
        step(0, 2'd1, 0, 0, 0, 6, 3, 1, 12'hC06, 0, 8'd0, "grad_h6v3");
        step(0, 2'd1, 0, 0, 0, 10, 3, 1, 12'hC0A, 0, 8'd0, "latch_hold");
        for (int i = 0; i < 4; i++)
            step(0, 2'd1, 0, 0, 1, 640 + i, 3, 1, 12'h000, 0, 8'd0, "blank_pre");

        // Bars line with NEXT_FRAME on H=0; counter update seen from the pulse output on
        for (int h = 0; h < 640; h++)
            step(0, 2'd1, 0, (h == 0), 0, h, 4, 1, bar_rgb(h / 80), (h < 2), 8'd1, "bars");
        for (int i = 0; i < 16; i++)
            step(0, 2'd1, 0, 0, 1, 640 + i, 4, 1, 12'h000, 0, 8'd0, "bars_blank");
        for (int h = 0; h < 100; h++)
            step(0, 2'd1, 0, 0, 0, h, 5, 1, bar_rgb(h / 80), 0, 8'd0, "bars_line2");
        step(0, 2'd1, 0, 0, 1, 640, 5, 1, 12'h000, 0, 8'd0, "blank");

        // Checker, frozen at frame 0
        step(1, 2'd2, 0, 0, 0, 100, 0, 1, 12'h000, 1, 8'd0, "reset_mid");
        step(0, 2'd2, 1, 0, 1, 640, 0, 1, 12'h000, 1, 8'd0, "blank");
        step(0, 2'd2, 1, 1, 0, 0, 0, 1, 12'h000, 1, 8'd0, "chk_nf_frz");
        for (int h = 1; h <= 40; h++) begin
            ex = ((h >> 5) & 1) ? 12'hFFF : 12'h000;
            step(0, 2'd2, 1, 0, 0, h, 0, 1, ex, 0, 8'd0, "chk_f0");
        end
        step(0, 2'd2, 0, 0, 1, 640, 0, 1, 12'h000, 0, 8'd0, "blank");
        // Advance one frame: H=31 now reads as 32 -> white
        step(0, 2'd2, 0, 1, 0, 0, 0, 1, 12'h000, 1, 8'd1, "chk_nf");
        for (int h = 1; h <= 40; h++) begin
            ex = (((h + 1) >> 5) & 1) ? 12'hFFF : 12'h000;
            step(0, 2'd2, 0, 0, 0, h, 0, 1, ex, 1, 8'd1, "chk_f1");
        end
        step(0, 2'd2, 0, 0, 1, 640, 32, 1, 12'h000, 0, 8'd0, "blank");
        for (int h = 0; h < 4; h++)
            step(0, 2'd2, 0, 0, 0, h, 32, 1, 12'hFFF, 0, 8'd0, "chk_v32");
        for (int i = 0; i < 3; i++)
            step(0, 2'd2, 1, 1, 1, 640, 0, 1, 12'h000, 1, 8'd1, "freeze");
        step(0, 2'd2, 1, 0, 1, 641, 0, 0, 12'h000, 1, 8'd1, "freeze_end");

        // Solid cycle over a full 256-frame wrap
        step(1, 2'd3, 0, 0, 0, 0, 10, 1, 12'h000, 1, 8'd0, "reset_solid");
        for (int i = 0; i < 256; i++) begin
            step(0, 2'd3, 0, 1, 0, 0, 10, 1, phase_rgb(i), 1, 8'((i + 1) % 256), "solid_nf");
            step(0, 2'd3, 0, 0, 0, 1, 10, 1, phase_rgb((i + 1) % 256), 1,
                 8'((i + 1) % 256), "solid");
        end
        step(0, 2'd3, 0, 0, 0, 2, 10, 1, 12'hF00, 1, 8'd0, "solid_wrap");
        step(0, 2'd3, 0, 0, 1, 640, 10, 1, 12'h000, 0, 8'd0, "blank");

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail + exp_q.size());
        $finish;
    end

endmodule
